stream_bus_mux: RTL

- Packet-aware, registered successor to the combinational word-select bus mux.
- Selects one of NUM_WORDS streaming input channels and locks to it for a whole packet, from the first accepted beat through the beat carrying eop.
- Drives a single registered output stream with valid/ready flow control.
- Sits between per-channel packet sources and a shared downstream consumer.

---
 rtl/stream_bus_mux_pkg.sv | 15 +
 rtl/stream_out_reg.sv | 33 +++
 rtl/stream_bus_mux.sv | 85 ++++++++
 3 files changed

// File: rtl/stream_bus_mux_pkg.sv
// Shared definitions for the packet-locking stream mux.
package stream_bus_mux_pkg;

  // Two-state lock FSM: wait for a requester, or forward one channel.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Bit offset of channel i inside the flattened input data bus.
  function automatic int unsigned slice_off(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready output register. Loads when the producer
// handshake fires, drains when downstream takes the beat; payload holds
// its value after the beat leaves.
module stream_out_reg #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] pin,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] pout,
  output logic         out_free
);

  // Room for a new beat when empty or when the current one leaves this cycle.
  assign out_free = !out_valid || out_ready;

  // Capture on load, otherwise retire the beat once it has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pout      <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      pout      <= pin;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_bus_mux.sv
// Packet-aware registered stream mux: locks onto the requested channel
// for a whole packet (or a single beat when PKT_MODE=0) and forwards it
// through a one-deep output register.
module stream_bus_mux
  import stream_bus_mux_pkg::*;
#(
  parameter int DAT_WIDTH = 16,
  parameter int SEL_WIDTH = 3,
  parameter int NUM_WORDS = 1 << SEL_WIDTH,
  parameter int TOTAL_DAT = DAT_WIDTH << SEL_WIDTH,
  parameter int PKT_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TOTAL_DAT-1:0] din,
  input  logic [NUM_WORDS-1:0] din_valid,
  input  logic [NUM_WORDS-1:0] din_eop,
  output logic [NUM_WORDS-1:0] din_ready,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [DAT_WIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 dout_eop,
  output logic [SEL_WIDTH-1:0] dout_ch,
  input  logic                 dout_ready,
  output logic                 busy
);

  localparam int PW = DAT_WIDTH + 1 + SEL_WIDTH;

  state_t                              state;
  logic [SEL_WIDTH-1:0]                cur_ch;
  logic [NUM_WORDS-1:0][DAT_WIDTH-1:0] ch_dat;
  logic                                out_free;
  logic                                accept;
  logic                                last;
  logic [PW-1:0]                       pin;
  logic [PW-1:0]                       pout;

  // Unflatten the input bus and grant ready only to the locked channel.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_ch
    assign ch_dat[g]    = din[slice_off(g, DAT_WIDTH) +: DAT_WIDTH];
    assign din_ready[g] = (state == ST_LOCKED) && (cur_ch == SEL_WIDTH'(g)) && out_free;
  end

  assign accept = (state == ST_LOCKED) && out_free && din_valid[cur_ch];
  // In beat mode every accepted beat ends the lock; eop is only carried along.
  assign last   = (PKT_MODE == 0) || din_eop[cur_ch];
  assign busy   = (state == ST_LOCKED);

  // Lock FSM: sel is only looked at in IDLE, so the lock is held for the packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur_ch <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (din_valid[sel]) begin
            cur_ch <= sel;
            state  <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept && last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pin = {din_eop[cur_ch], cur_ch, ch_dat[cur_ch]};
  assign {dout_eop, dout_ch, dout} = pout;

  stream_out_reg #(.W(PW)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .pin       (pin),
    .out_ready (dout_ready),
    .out_valid (dout_valid),
    .pout      (pout),
    .out_free  (out_free)
  );

endmodule
